// File: rtl/prog_clock_divider_if.sv
// prog_clock_divider_if: configuration handshake bundle for prog_clock_divider.
// master = side that offers a new divisor/high time, slave = the divider.
interface prog_clock_divider_if #(
  parameter int CNT_W = 16
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_high,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_high,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: runtime-programmable integer clock divider with
// programmable high time. clk_out is registered; rise/fall strobes are
// provided for logic running on clk_in. New settings arrive over a
// valid/ready handshake and only take effect at a period boundary, and a
// disable request always lets the current period finish.
//
// Optional build macro: PROG_CLOCK_DIVIDER_SYNC_EN adds i_sync_in, whose
// rising edge (registered, one cycle of latency) forces a period restart
// so the output can be phase-aligned to an external reference.
module prog_clock_divider #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = 2,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 i_enable,
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
  input  logic                 i_sync_in,
`endif
  prog_clock_divider_if.slave  cfg,
  output logic                 o_clk_out,
  output logic                 o_rise_tick,
  output logic                 o_fall_tick,
  output logic                 o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_DEF_HIGH = CNT_W'(DEFAULT_HIGH);

  // Registered state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             r_rise_tick;
  logic             r_fall_tick;
  logic             r_cfg_err;
  logic             r_cfg_ready;   // low exactly while the pending slot is occupied
  logic [CNT_W-1:0] r_act_div;
  logic [CNT_W-1:0] r_act_high;
  logic [CNT_W-1:0] r_pend_div;
  logic [CNT_W-1:0] r_pend_high;

  // Next-state values
  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_clk_next;
  logic             w_rise_next;
  logic             w_fall_next;
  logic             w_apply;       // this edge is a point where a pending config may land
  logic             w_cfg_err_next;
  logic             w_cfg_ready_next;
  logic [CNT_W-1:0] w_act_div_next;
  logic [CNT_W-1:0] w_act_high_next;
  logic [CNT_W-1:0] w_pend_div_next;
  logic [CNT_W-1:0] w_pend_high_next;

  logic             w_boundary;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cfg_ok;

  assign w_boundary = (r_cnt == (r_act_div - C_ONE));
  assign w_cnt_inc  = r_cnt + C_ONE;
  assign w_cfg_ok   = (cfg.cfg_div >= C_TWO) && (cfg.cfg_high != '0) &&
                      (cfg.cfg_high < cfg.cfg_div);

`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
  logic r_sync_prev;
  logic r_sync_edge;

  // Registered rising-edge detector on the external sync reference
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sync_prev <= 1'b0;
      r_sync_edge <= 1'b0;
    end else begin
      r_sync_prev <= i_sync_in;
      r_sync_edge <= i_sync_in & ~r_sync_prev;
    end
  end
`endif

  // FSM next-state and waveform generation
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_clk_next   = r_clk_out;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    w_apply      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Idle: a pending config lands on the very next edge.
        w_apply = 1'b1;
        if (i_enable) begin
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
          w_clk_next   = 1'b1;
          w_rise_next  = 1'b1;
        end
      end
      ST_RUN, ST_STOP_PEND: begin
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
        // Sync restart: new period from this edge, stop request (if any) stays armed.
        if (r_sync_edge) begin
          w_apply      = 1'b1;
          w_cnt_next   = '0;
          w_clk_next   = 1'b1;
          w_rise_next  = 1'b1;
          w_state_next = i_enable ? ST_RUN : ST_STOP_PEND;
        end else
`endif
        if (w_boundary) begin
          // Period complete. Enable sampled here decides between another
          // period and stopping; stopping never starts a new period.
          w_apply    = 1'b1;
          w_cnt_next = '0;
          if (i_enable) begin
            w_state_next = ST_RUN;
            w_clk_next   = 1'b1;
            w_rise_next  = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
            w_clk_next   = 1'b0;
          end
        end else begin
          w_cnt_next   = w_cnt_inc;
          w_state_next = i_enable ? ST_RUN : ST_STOP_PEND;
          if (w_cnt_inc == r_act_high) begin
            w_clk_next  = 1'b0;
            w_fall_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
        w_clk_next   = 1'b0;
      end
    endcase
  end

  // Config handshake: accept into the pending slot, apply at boundaries.
  always_comb begin
    w_cfg_err_next   = 1'b0;
    w_cfg_ready_next = r_cfg_ready;
    w_act_div_next   = r_act_div;
    w_act_high_next  = r_act_high;
    w_pend_div_next  = r_pend_div;
    w_pend_high_next = r_pend_high;
    if (w_apply && !r_cfg_ready) begin
      w_act_div_next   = r_pend_div;
      w_act_high_next  = r_pend_high;
      w_cfg_ready_next = 1'b1;
    end else if (cfg.cfg_valid && r_cfg_ready) begin
      if (w_cfg_ok) begin
        w_pend_div_next  = cfg.cfg_div;
        w_pend_high_next = cfg.cfg_high;
        w_cfg_ready_next = 1'b0;
      end else begin
        w_cfg_err_next = 1'b1;
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_clk_out   <= 1'b0;
      r_rise_tick <= 1'b0;
      r_fall_tick <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_act_div   <= C_DEF_DIV;
      r_act_high  <= C_DEF_HIGH;
      r_pend_div  <= '0;
      r_pend_high <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_clk_out   <= w_clk_next;
      r_rise_tick <= w_rise_next;
      r_fall_tick <= w_fall_next;
      r_cfg_err   <= w_cfg_err_next;
      r_cfg_ready <= w_cfg_ready_next;
      r_act_div   <= w_act_div_next;
      r_act_high  <= w_act_high_next;
      r_pend_div  <= w_pend_div_next;
      r_pend_high <= w_pend_high_next;
    end
  end

  assign o_clk_out     = r_clk_out;
  assign o_rise_tick   = r_rise_tick;
  assign o_fall_tick   = r_fall_tick;
  assign o_busy        = (r_state != ST_IDLE);
  assign cfg.cfg_ready = r_cfg_ready;
  assign cfg.cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed + randomized bench for prog_clock_divider.
// The reference model works per period: when a period starts it queues the
// whole list of expected (clk_out, rise, fall) samples for that period.
module tb_prog_clock_divider;
  localparam int CNT_W = 16;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
  logic sync_in = 1'b0;
`endif
  logic clk_out, rise_tick, fall_tick, busy;

  prog_clock_divider_if #(.CNT_W(CNT_W)) cfg_if ();

  prog_clock_divider #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2),
    .DEFAULT_HIGH(1)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .i_enable   (enable),
`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
    .i_sync_in  (sync_in),
`endif
    .cfg        (cfg_if),
    .o_clk_out  (clk_out),
    .o_rise_tick(rise_tick),
    .o_fall_tick(fall_tick),
    .o_busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int       m_div, m_high, m_pdiv, m_phigh;
  bit       m_pend, m_busy, m_ready, m_err;
  bit       m_clk, m_rise, m_fall;
  bit [2:0] q[$];   // remaining samples of the current period: {clk, rise, fall}

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_div = 2; m_high = 1; m_pdiv = 0; m_phigh = 0;
    m_pend = 0; m_busy = 0; m_ready = 1; m_err = 0;
    m_clk = 0; m_rise = 0; m_fall = 0;
    q.delete();
  endfunction

  function automatic void load_period();
    q.delete();
    for (int k = 0; k < m_div; k++) begin
      bit [2:0] s;
      s[2] = (k < m_high);
      s[1] = (k == 0);
      s[0] = (k == m_high);
      q.push_back(s);
    end
  endfunction

  function automatic void model_edge();
    bit       old_ready;
    bit [2:0] s;
    int       d, h;
    old_ready = m_ready;
    m_err = 0;
    // Idle, or the current period has been fully emitted: a boundary.
    if (!m_busy || q.size() == 0) begin
      if (m_pend) begin
        m_div = m_pdiv; m_high = m_phigh; m_pend = 0; m_ready = 1;
      end
      if (enable) begin
        m_busy = 1;
        load_period();
      end else begin
        m_busy = 0;
        q.delete();
      end
    end
    if (m_busy) begin
      s = q.pop_front();
      m_clk = s[2]; m_rise = s[1]; m_fall = s[0];
    end else begin
      m_clk = 0; m_rise = 0; m_fall = 0;
    end
    if (cfg_if.cfg_valid && old_ready) begin
      d = int'(cfg_if.cfg_div);
      h = int'(cfg_if.cfg_high);
      if (d >= 2 && h >= 1 && h < d) begin
        m_pend = 1; m_pdiv = d; m_phigh = h; m_ready = 0;
      end else begin
        m_err = 1;
      end
    end
  endfunction

  // One clk_in cycle: model follows the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk_in);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk_in);
    chk("clk_out",   clk_out,          m_clk);
    chk("rise_tick", rise_tick,        m_rise);
    chk("fall_tick", fall_tick,        m_fall);
    chk("busy",      busy,             m_busy);
    chk("cfg_ready", cfg_if.cfg_ready, m_ready);
    chk("cfg_err",   cfg_if.cfg_err,   m_err);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold an offer until it transfers (or max_wait edges pass).
  task automatic offer(int d, int h, int max_wait);
    bit acc;
    acc = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = CNT_W'(d);
    cfg_if.cfg_high  = CNT_W'(h);
    for (int i = 0; i < max_wait && !acc; i++) begin
      acc = cfg_if.cfg_ready;
      step();
    end
    cfg_if.cfg_valid = 1'b0;
    $display("cfg offer div=%0d high=%0d transferred=%0b cfg_err=%0b", d, h, acc, cfg_if.cfg_err);
  endtask

  task automatic wait_rise(int limit);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!rise_tick && n < limit);
    chk("wait_rise", rise_tick, 1);
  endtask

  task automatic raw_step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    int rc, r, d, h;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_high  = '0;
    model_reset();

    // Reset state
    steps(3);
    chk("reset_busy",  busy, 0);
    chk("reset_ready", cfg_if.cfg_ready, 1);
    chk("reset_clk",   clk_out, 0);

    // Default 2/1 waveform from reset release
    reset  = 1'b0;
    enable = 1'b1;
    step();
    chk("default_first_rise", clk_out, 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("default_wave", clk_out, (i % 2 == 0));
    end

    // Switch to 5/2 at the next boundary
    offer(5, 2, 10);
    wait_rise(10);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("div5_clk",  clk_out,   ((i % 5) < 2));
      chk("div5_rise", rise_tick, ((i % 5) == 0));
      chk("div5_fall", fall_tick, ((i % 5) == 2));
    end

    // Invalid configs are rejected without disturbing the waveform
    offer(1, 1, 5);
    chk("err_div1", cfg_if.cfg_err, 1);
    step();
    offer(4, 4, 5);
    chk("err_high_eq_div", cfg_if.cfg_err, 1);
    chk("ready_after_err", cfg_if.cfg_ready, 1);
    steps(6);

    // 8/4: disable at cnt=2 finishes the period, then idles
    offer(8, 4, 10);
    wait_rise(20);
    steps(2);
    enable = 1'b0;
    rc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rise_tick) rc++;
    end
    chk("stop_no_rise", rc, 0);
    chk("stop_idle", busy, 0);

    // Re-enable at cnt=6 during the stop request: no gap
    enable = 1'b1;
    wait_rise(3);
    steps(2);
    enable = 1'b0;
    steps(4);
    enable = 1'b1;
    steps(2);
    chk("no_gap_rise", rise_tick, 1);

    // Reset mid-period with a config still pending
    offer(6, 3, 10);
    wait_rise(20);
    wait_rise(10);
    steps(2);
    offer(9, 4, 1);
    reset = 1'b1;
    #1;
    chk("async_clk",   clk_out, 0);
    chk("async_ready", cfg_if.cfg_ready, 1);
    chk("async_busy",  busy, 0);
    model_reset();
    steps(2);
    reset = 1'b0;
    step();
    chk("post_reset_clk0", clk_out, 1);
    step();
    chk("post_reset_clk1", clk_out, 0);
    step();
    chk("post_reset_clk2", clk_out, 1);

    // Randomized phase: enable toggles, valid/invalid offers, occasional reset
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else if (r < 80) begin
        d = int'($urandom_range(0, 14));
        h = int'($urandom_range(0, d + 1));
        offer(d, h, 1);
      end else begin
        if (r < 100) enable = ~enable;
        step();
      end
    end

`ifdef PROG_CLOCK_DIVIDER_SYNC_EN
    // Sync pulse at cnt=4 of a 10-cycle period restarts the period two edges later
    enable = 1'b1;
    offer(10, 5, 20);
    wait_rise(40);
    wait_rise(20);
    steps(4);
    sync_in = 1'b1;
    raw_step();
    sync_in = 1'b0;
    raw_step();
    chk("sync_rise", rise_tick, 1);
    for (int i = 1; i <= 10; i++) begin
      raw_step();
      chk("sync_period", rise_tick, (i == 10));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
